// File: rtl/image_frame_writer_pkg.sv
// Shared types and defaults for the processed-pixel sink and its stream producer.
// Holds writer FSM encodings, default image geometry and producer operation codes.
package image_frame_writer_pkg;

  typedef enum logic [1:0] {
    WR_IDLE  = 2'd0,
    WR_RUN   = 2'd1,
    WR_DRAIN = 2'd2,
    WR_DONE  = 2'd3
  } wr_state_t;

  localparam int DEF_IMG_WIDTH  = 64;
  localparam int DEF_IMG_HEIGHT = 64;
  localparam int DEF_PIX_W      = 8;

  typedef enum logic [2:0] {
    OP_PASS      = 3'd0,
    OP_THRESHOLD = 3'd1,
    OP_BRIGHT    = 3'd2,
    OP_INVERT    = 3'd3,
    OP_CONTRAST  = 3'd4
  } pix_op_t;

endpackage

// File: rtl/pix_sync_fifo.sv
// Synchronous pixel FIFO with registered full/empty; push result visible one cycle later.
// No fall-through; push is ignored when full and pop is ignored when empty.
module pix_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      cnt_nxt;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_comb begin
    cnt_nxt = count;
    if (do_push && !do_pop)
      cnt_nxt = count + 1'b1;
    else if (do_pop && !do_push)
      cnt_nxt = count - 1'b1;
  end

  // Storage is cleared too so the write-data port reads zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= cnt_nxt;
      full  <= (cnt_nxt == (AW+1)'(DEPTH));
      empty <= (cnt_nxt == '0);
    end
  end

endmodule

// File: rtl/image_frame_writer.sv
// Buffers one frame of pixels and writes them in raster order to a stallable frame memory.
// Pixel writable one cycle after accept; memory stalls fill the FIFO, then in_ready drops.
module image_frame_writer
  import image_frame_writer_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int PIX_W      = DEF_PIX_W,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [PIX_W-1:0]  in_data,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [PIX_W-1:0]  mem_wdata,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_error,
  output logic [ADDR_W:0]   pix_count
);

  localparam int              CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W:0] N_PIX    = (ADDR_W+1)'(IMG_WIDTH * IMG_HEIGHT);
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(IMG_WIDTH * IMG_HEIGHT - 1);

  wr_state_t        state, state_nxt;
  logic [ADDR_W:0]  acc_cnt, wr_cnt;
  logic             err_q;
  logic             fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_cnt;
  logic [PIX_W-1:0] fifo_head;
  logic             accept, at_last_idx;

  assign in_ready    = (state == WR_RUN) && !fifo_full;
  assign accept      = in_valid && in_ready;
  assign at_last_idx = (acc_cnt == LAST_IDX);
  assign mem_we      = !fifo_empty && mem_ready && (state == WR_RUN || state == WR_DRAIN);
  assign mem_addr    = wr_cnt[ADDR_W-1:0];
  assign mem_wdata   = fifo_head;
  assign busy        = (state != WR_IDLE);
  assign frame_done  = (state == WR_DONE);
  assign frame_error = err_q;
  assign pix_count   = acc_cnt;

  pix_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PIX_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (accept),
    .push_dat (in_data),
    .pop      (mem_we),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_cnt)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      WR_IDLE:  if (start) state_nxt = WR_RUN;
      WR_RUN:   if (accept && at_last_idx) state_nxt = WR_DRAIN;
      WR_DRAIN: if (fifo_cnt == '0 && wr_cnt == N_PIX) state_nxt = WR_DONE;
      WR_DONE:  state_nxt = WR_IDLE;
      default:  state_nxt = WR_IDLE;
    endcase
  end

  // A framing error never shortens the frame; completion is purely by pixel count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= WR_IDLE;
      acc_cnt <= '0;
      wr_cnt  <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == WR_IDLE && start) begin
        acc_cnt <= '0;
        wr_cnt  <= '0;
        err_q   <= 1'b0;
      end else begin
        if (accept && acc_cnt != N_PIX)
          acc_cnt <= acc_cnt + 1'b1;
        if (mem_we)
          wr_cnt <= wr_cnt + 1'b1;
        if (accept && (in_last != at_last_idx))
          err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_image_frame_writer.sv
// Self-checking bench for image_frame_writer on a 4x4 frame with a 4-entry FIFO.
// Expected writes come from the offered pixel list: address i must carry pixel i, once each.
module tb_image_frame_writer;

  localparam int W = 4, H = 4, N = 16, PW = 8, DEPTH = 4, AW = 12;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, in_last, mem_ready;
  logic [PW-1:0] in_data;
  logic          in_ready, mem_we, busy, frame_done, frame_error;
  logic [AW-1:0] mem_addr;
  logic [PW-1:0] mem_wdata;
  logic [AW:0]   pix_count;

  int checks = 0;
  int errors = 0;

  logic [PW-1:0] pix [0:N];
  int            wr_addr_q [$];
  logic [PW-1:0] wr_data_q [$];
  int            done_cnt, acc_n, err_idx, stall_occ;

  always #5 clk = ~clk;

  image_frame_writer #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .PIX_W      (PW),
    .FIFO_DEPTH (DEPTH),
    .ADDR_W     (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .mem_ready   (mem_ready),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_error (frame_error),
    .pix_count   (pix_count)
  );

  // Drives one frame (plus one surplus pixel) and records what the memory port saw.
  task automatic drive_frame(input int last_idx, input int stall_at, input int stall_len,
                             input int start_at, input int abort_at,
                             input bit rnd_gap, input bit rnd_mem);
    int cyc  = 0;
    int post = 0;
    wr_addr_q.delete();
    wr_data_q.delete();
    done_cnt = 0; acc_n = 0; err_idx = -1; stall_occ = -1;
    while (cyc < 400) begin
      @(posedge clk); #1;
      if (post >= 3 || acc_n >= abort_at) break;
      start     = (cyc == 0) || (acc_n == start_at);
      in_valid  = rnd_gap ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data   = pix[acc_n];
      in_last   = (acc_n == last_idx);
      mem_ready = !(cyc >= stall_at && cyc < stall_at + stall_len) &&
                  (!rnd_mem || $urandom_range(0, 2) != 0);
      @(negedge clk);
      if (busy && frame_error && err_idx < 0) err_idx = acc_n;
      if (cyc >= stall_at && cyc < stall_at + stall_len && busy && acc_n < N &&
          !in_ready && stall_occ < 0)
        stall_occ = acc_n - wr_addr_q.size();
      if (mem_we) begin
        wr_addr_q.push_back(int'(mem_addr));
        wr_data_q.push_back(mem_wdata);
      end
      if (frame_done) done_cnt++;
      if (in_valid && in_ready) acc_n++;
      cyc++;
      if (done_cnt > 0) post++;
    end
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0; mem_ready = 1'b1;
  endtask

  task automatic fill_random();
    for (int i = 0; i <= N; i++) pix[i] = PW'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    checks++; if (mem_we !== 1'b0)    begin errors++; $display("FAIL reset_mem_we got %b exp 0", mem_we); end
    checks++; if (mem_addr !== '0)    begin errors++; $display("FAIL reset_mem_addr got %0d exp 0", mem_addr); end
    checks++; if (mem_wdata !== '0)   begin errors++; $display("FAIL reset_mem_wdata got %0h exp 0", mem_wdata); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b exp 0", frame_done); end
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_frame_error got %b exp 0", frame_error); end
    checks++; if (pix_count !== '0)   begin errors++; $display("FAIL reset_pix_count got %0d exp 0", pix_count); end
    rst = 1'b0;
  endtask

  task automatic test_nominal();
    for (int i = 0; i <= N; i++) pix[i] = PW'(i);
    drive_frame(N - 1, 1000, 0, -1, 99, 1'b0, 1'b0);
    checks++; if (wr_addr_q.size() != N) begin errors++; $display("FAIL nominal_nwrites got %0d exp %0d", wr_addr_q.size(), N); end
    for (int i = 0; i < N && i < wr_addr_q.size(); i++) begin
      checks++;
      if (wr_addr_q[i] != i || wr_data_q[i] !== pix[i]) begin
        errors++; $display("FAIL nominal_write[%0d] got addr %0d data %0h exp addr %0d data %0h", i, wr_addr_q[i], wr_data_q[i], i, pix[i]);
      end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL nominal_done got %0d pulses exp 1", done_cnt); end
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL nominal_error got %b exp 0", frame_error); end
    checks++; if (pix_count !== (AW+1)'(N)) begin errors++; $display("FAIL nominal_pix_count got %0d exp %0d", pix_count, N); end
  endtask

  task automatic test_stall();
    fill_random();
    drive_frame(N - 1, 5, 10, -1, 99, 1'b0, 1'b0);
    checks++; if (stall_occ != DEPTH) begin errors++; $display("FAIL stall_occupancy got %0d exp %0d", stall_occ, DEPTH); end
    checks++; if (wr_addr_q.size() != N) begin errors++; $display("FAIL stall_nwrites got %0d exp %0d", wr_addr_q.size(), N); end
    for (int i = 0; i < N && i < wr_addr_q.size(); i++) begin
      checks++;
      if (wr_addr_q[i] != i || wr_data_q[i] !== pix[i]) begin
        errors++; $display("FAIL stall_write[%0d] got addr %0d data %0h exp addr %0d data %0h", i, wr_addr_q[i], wr_data_q[i], i, pix[i]);
      end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL stall_done got %0d exp 1", done_cnt); end
  endtask

  task automatic test_early_last();
    fill_random();
    drive_frame(9, 1000, 0, -1, 99, 1'b0, 1'b0);
    checks++; if (err_idx != 10) begin errors++; $display("FAIL early_err_index got %0d exp 10", err_idx); end
    checks++; if (wr_addr_q.size() != N) begin errors++; $display("FAIL early_nwrites got %0d exp %0d", wr_addr_q.size(), N); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL early_done got %0d exp 1", done_cnt); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (frame_error !== 1'b1) begin errors++; $display("FAIL early_error_sticky got %b exp 1", frame_error); end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL early_error_clear got %b exp 0", frame_error); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL early_restart_busy got %b exp 1", busy); end
    fill_random();
    drive_frame(N - 1, 1000, 0, -1, 99, 1'b1, 1'b1);
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL early_clean_frame_error got %b exp 0", frame_error); end
    checks++; if (wr_addr_q.size() != N) begin errors++; $display("FAIL early_clean_nwrites got %0d exp %0d", wr_addr_q.size(), N); end
  endtask

  task automatic test_missing_last();
    fill_random();
    drive_frame(-1, 1000, 0, -1, 99, 1'b0, 1'b0);
    checks++; if (err_idx != N) begin errors++; $display("FAIL missing_err_index got %0d exp %0d", err_idx, N); end
    checks++; if (acc_n != N) begin errors++; $display("FAIL missing_accepted got %0d exp %0d", acc_n, N); end
    checks++; if (pix_count !== (AW+1)'(N)) begin errors++; $display("FAIL missing_pix_count got %0d exp %0d", pix_count, N); end
    checks++; if (frame_error !== 1'b1) begin errors++; $display("FAIL missing_error got %b exp 1", frame_error); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL missing_done got %0d exp 1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    fill_random();
    drive_frame(N - 1, 1000, 0, -1, 6, 1'b0, 1'b0);
    checks++; if (pix_count !== (AW+1)'(6)) begin errors++; $display("FAIL midrst_pre_count got %0d exp 6", pix_count); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL midrst_mem_we got %b exp 0", mem_we); end
    checks++; if (pix_count !== '0) begin errors++; $display("FAIL midrst_pix_count got %0d exp 0", pix_count); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL midrst_frame_done got %b exp 0", frame_done); end
    rst = 1'b0;
    fill_random();
    drive_frame(N - 1, 1000, 0, -1, 99, 1'b1, 1'b0);
    checks++; if (wr_addr_q.size() != N) begin errors++; $display("FAIL midrst_nwrites got %0d exp %0d", wr_addr_q.size(), N); end
    for (int i = 0; i < N && i < wr_addr_q.size(); i++) begin
      checks++;
      if (wr_addr_q[i] != i || wr_data_q[i] !== pix[i]) begin
        errors++; $display("FAIL midrst_write[%0d] got addr %0d data %0h exp addr %0d data %0h", i, wr_addr_q[i], wr_data_q[i], i, pix[i]);
      end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL midrst_done got %0d exp 1", done_cnt); end
  endtask

  task automatic test_start_busy();
    fill_random();
    drive_frame(N - 1, 1000, 0, 5, 99, 1'b1, 1'b1);
    checks++; if (pix_count !== (AW+1)'(N)) begin errors++; $display("FAIL busystart_pix_count got %0d exp %0d", pix_count, N); end
    checks++; if (wr_addr_q.size() != N) begin errors++; $display("FAIL busystart_nwrites got %0d exp %0d", wr_addr_q.size(), N); end
    for (int i = 0; i < N && i < wr_addr_q.size(); i++) begin
      checks++;
      if (wr_addr_q[i] != i || wr_data_q[i] !== pix[i]) begin
        errors++; $display("FAIL busystart_write[%0d] got addr %0d data %0h exp addr %0d data %0h", i, wr_addr_q[i], wr_data_q[i], i, pix[i]);
      end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL busystart_done got %0d exp 1", done_cnt); end
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL busystart_error got %b exp 0", frame_error); end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 2; f++) begin
      fill_random();
      drive_frame(N - 1, 1000, 0, -1, 99, 1'b1, 1'b1);
      checks++; if (wr_addr_q.size() != N) begin errors++; $display("FAIL b2b%0d_nwrites got %0d exp %0d", f, wr_addr_q.size(), N); end
      for (int i = 0; i < N && i < wr_addr_q.size(); i++) begin
        checks++;
        if (wr_addr_q[i] != i || wr_data_q[i] !== pix[i]) begin
          errors++; $display("FAIL b2b%0d_write[%0d] got addr %0d data %0h exp addr %0d data %0h", f, i, wr_addr_q[i], wr_data_q[i], i, pix[i]);
        end
      end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL b2b%0d_done got %0d exp 1", f, done_cnt); end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; mem_ready = 1'b1;
    test_reset();
    test_nominal();
    test_stall();
    test_early_last();
    test_missing_last();
    test_reset_mid();
    test_start_busy();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
